fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Next-generation synchronous FIFO with generic width/depth and runtime almost-full/empty thresholds.
//  Adds an occupancy count, a hysteretic pause (flow control back to the producer) and a sticky, clearable error.
//  Drop-in buffer between a producer (Fifo_wr/Fifo_Data_in) and a consumer (Fifo_rd/Fifo_Data_out).
// PARAMETERS
//  BITNUMBER  6  data word width in bits
//  LENGTH     8  depth in words; power of two, >=2
//  PTR_W      $clog2(LENGTH)  localparam, pointer width; count/threshold width is PTR_W+1
// PORTS
//  clk            in   1            single clock, all logic on rising edge
//  reset          in   1            synchronous, active-high
//  Fifo_wr        in   1            write request
//  Fifo_rd        in   1            read request
//  Fifo_Data_in   in   BITNUMBER    write data
//  umbral_af      in   PTR_W+1      almost-full threshold, words
//  umbral_ae      in   PTR_W+1      almost-empty threshold, words
//  error_clr      in   1            clears sticky Fifo_error
//  Fifo_Data_out  out  BITNUMBER    registered read data
//  valid_read     out  1            Fifo_Data_out carries newly popped word
//  Fifo_count     out  PTR_W+1      occupancy, 0..LENGTH
//  Fifo_full / Fifo_empty           out 1  count==LENGTH / count==0
//  almost_full / almost_empty       out 1  count>=umbral_af / count<=umbral_ae
//  can_pop        out  1            !Fifo_empty
//  pause          out  1            registered hysteretic back-pressure
//  Fifo_wr_error / Fifo_rd_error    out 1  one-cycle overflow / underflow pulse
//  Fifo_error     out  1            sticky OR of both error pulses
// BEHAVIOUR
//  Reset (sync): wr_ptr=rd_ptr=0, count=0, Fifo_Data_out=0, valid_read=0, pause=0, all errors 0;
//   hence Fifo_empty=1, can_pop=0, Fifo_full=0, almost_empty=1 (for any umbral_ae). Memory array not
//   cleared. Reset mid-operation discards all contents; requests in the reset cycle are ignored.
//  Write accepted iff Fifo_wr && (!Fifo_full || Fifo_rd): mem[wr_ptr]<=Fifo_Data_in, wr_ptr+1 mod LENGTH.
//  Read accepted iff Fifo_rd && !Fifo_empty: Fifo_Data_out<=mem[rd_ptr] next edge, valid_read=1 for that
//   single cycle, rd_ptr+1 mod LENGTH. No read: Fifo_Data_out holds, valid_read=0. Latency write->readable 1 cycle.
//  Simultaneous rd+wr: full -> both accepted, count unchanged; empty -> write accepted, read rejected
//   (no bypass), rd_error pulses.
//  Count: +1 write-only, -1 read-only, unchanged both/neither accepted; never exceeds LENGTH or goes <0.
//  Fifo_wr_error=1 for one cycle after Fifo_wr rejected (full, no read); Fifo_rd_error likewise for read
//   when empty. Rejected ops change no state.
//  Fifo_error: set on any error pulse, cleared by error_clr; set wins when both in same cycle.
//  Flags full/empty/almost_*/can_pop are combinational from registered count and live thresholds.
//  pause next = (count>=umbral_af) ? 1 : (count<=umbral_ae) ? 0 : pause (evaluated on current count, so
//   pause lags count by one cycle). If umbral_ae>=umbral_af the set term has priority.
//  pause is advisory only; writes are still accepted while pause=1 until full.
// TESTING  (BITNUMBER=6, LENGTH=8, umbral_af=6, umbral_ae=2)
//  Reset then idle -> empty=1, almost_empty=1, count=0, pause=0, all errors 0, Fifo_Data_out=0.
//  Write 1..8, read 8 -> data 1..8 in order, valid_read 1 cycle each, full at count 8, wrap of both ptrs.
//  Write 9th word when full -> Fifo_wr_error 1 cycle, Fifo_error sticky, count stays 8; error_clr -> 0.
//  Fill to 6 -> pause=1 cycle after count=6; drain to 3 -> pause still 1; to 2 -> pause=0 next cycle.
//  Full + rd&wr same cycle -> count stays 8, word out oldest, new word last; empty + rd&wr -> rd_error, count 1.
//  Reset asserted at count=5 -> next cycle count=0, empty=1, pause=0, subsequent read -> rd_error.

Source files
------------

// File: rtl/fifo_param.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds, occupancy count,
// hysteretic pause output for producer back-pressure, and a sticky, clearable error flag.
module fifo_param #(
    parameter int BITNUMBER = 6,
    parameter int LENGTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Fifo_wr,
    input  logic                    Fifo_rd,
    input  logic [BITNUMBER-1:0]    Fifo_Data_in,
    input  logic [$clog2(LENGTH):0] umbral_af,
    input  logic [$clog2(LENGTH):0] umbral_ae,
    input  logic                    error_clr,
    output logic [BITNUMBER-1:0]    Fifo_Data_out,
    output logic                    valid_read,
    output logic [$clog2(LENGTH):0] Fifo_count,
    output logic                    Fifo_full,
    output logic                    Fifo_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    can_pop,
    output logic                    pause,
    output logic                    Fifo_wr_error,
    output logic                    Fifo_rd_error,
    output logic                    Fifo_error
);

    localparam int PTR_W = $clog2(LENGTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LENGTH);

    logic [BITNUMBER-1:0] mem [LENGTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic wr_accept;
    logic rd_accept;
    logic wr_reject;
    logic rd_reject;

    // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
    assign wr_accept = Fifo_wr && (!Fifo_full || Fifo_rd);
    assign rd_accept = Fifo_rd && !Fifo_empty;
    assign wr_reject = Fifo_wr && !wr_accept;
    assign rd_reject = Fifo_rd && !rd_accept;

    assign Fifo_count   = count;
    assign Fifo_full    = (count == FULL_COUNT);
    assign Fifo_empty   = (count == '0);
    assign almost_full  = (count >= umbral_af);
    assign almost_empty = (count <= umbral_ae);
    assign can_pop      = !Fifo_empty;

    // Storage is deliberately left out of reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem[wr_ptr] <= Fifo_Data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            Fifo_Data_out <= '0;
            valid_read    <= 1'b0;
        end else begin
            valid_read <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                Fifo_Data_out <= mem[rd_ptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Set term beats clear term so a fault in the same cycle as error_clr is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            Fifo_wr_error <= 1'b0;
            Fifo_rd_error <= 1'b0;
            Fifo_error    <= 1'b0;
        end else begin
            Fifo_wr_error <= wr_reject;
            Fifo_rd_error <= rd_reject;
            if (wr_reject || rd_reject) begin
                Fifo_error <= 1'b1;
            end else if (error_clr) begin
                Fifo_error <= 1'b0;
            end
        end
    end

    // Hysteresis: assert at the almost-full level, release only once drained to almost-empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause <= 1'b0;
        end else if (count >= umbral_af) begin
            pause <= 1'b1;
        end else if (count <= umbral_ae) begin
            pause <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_param;

    logic       clk;
    logic       reset;
    logic       fifo_wr;
    logic       fifo_rd;
    logic [5:0] fifo_din;
    logic [3:0] umbral_af;
    logic [3:0] umbral_ae;
    logic       error_clr;
    logic [5:0] fifo_dout;
    logic       valid_read;
    logic [3:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic       can_pop;
    logic       pause;
    logic       wr_error;
    logic       rd_error;
    logic       fifo_error;

    int total;
    int bad;

    logic [5:0] q[$];
    logic [5:0] exp_dout;
    logic       exp_valid;
    logic       exp_pause;
    logic       exp_wr_err;
    logic       exp_rd_err;
    logic       exp_err;

    fifo_param #(.BITNUMBER(6), .LENGTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .Fifo_wr       (fifo_wr),
        .Fifo_rd       (fifo_rd),
        .Fifo_Data_in  (fifo_din),
        .umbral_af     (umbral_af),
        .umbral_ae     (umbral_ae),
        .error_clr     (error_clr),
        .Fifo_Data_out (fifo_dout),
        .valid_read    (valid_read),
        .Fifo_count    (fifo_count),
        .Fifo_full     (fifo_full),
        .Fifo_empty    (fifo_empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .can_pop       (can_pop),
        .pause         (pause),
        .Fifo_wr_error (wr_error),
        .Fifo_rd_error (rd_error),
        .Fifo_error    (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one clock of requests and advances the reference model by the same rules.
    task automatic cycle(input logic wr, input logic rd, input logic [5:0] din, input logic clr);
        int   sz;
        logic wr_ok;
        logic rd_ok;
        logic nxt_pause;
        sz        = q.size();
        fifo_wr   = wr;
        fifo_rd   = rd;
        fifo_din  = din;
        error_clr = clr;
        wr_ok = wr && ((sz != 8) || rd);
        rd_ok = rd && (sz != 0);
        if (sz >= int'(umbral_af))      nxt_pause = 1'b1;
        else if (sz <= int'(umbral_ae)) nxt_pause = 1'b0;
        else                            nxt_pause = exp_pause;
        if (rd_ok) exp_dout = q.pop_front();
        exp_valid = rd_ok;
        if (wr_ok) q.push_back(din);
        exp_wr_err = wr && !wr_ok;
        exp_rd_err = rd && !rd_ok;
        if (exp_wr_err || exp_rd_err) exp_err = 1'b1;
        else if (clr)                 exp_err = 1'b0;
        exp_pause = nxt_pause;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        reset   = 1'b1;
        fifo_wr = wr;
        fifo_rd = rd;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        fifo_wr    = 1'b0;
        fifo_rd    = 1'b0;
        error_clr  = 1'b0;
        q.delete();
        exp_dout   = '0;
        exp_valid  = 1'b0;
        exp_pause  = 1'b0;
        exp_wr_err = 1'b0;
        exp_rd_err = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        cycle(1'b0, 1'b0, 6'd0, 1'b0);
        total++; if (fifo_empty !== 1'b1)   begin bad++; $display("[TB] FAIL reset_empty got=%b exp=1", fifo_empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_almost_empty got=%b exp=1", almost_empty); end
        total++; if (fifo_count !== 4'd0)   begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (pause !== 1'b0)        begin bad++; $display("[TB] FAIL reset_pause got=%b exp=0", pause); end
        total++; if (fifo_full !== 1'b0)    begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", fifo_full); end
        total++; if (can_pop !== 1'b0)      begin bad++; $display("[TB] FAIL reset_can_pop got=%b exp=0", can_pop); end
        total++; if ({wr_error, rd_error, fifo_error} !== 3'b000)
            begin bad++; $display("[TB] FAIL reset_errors got=%b exp=000", {wr_error, rd_error, fifo_error}); end
        total++; if (fifo_dout !== 6'd0)    begin bad++; $display("[TB] FAIL reset_dout got=%0d exp=0", fifo_dout); end
        total++; if (valid_read !== 1'b0)   begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_read); end
    endtask

    task automatic test_fill_drain();
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 6'(i), 1'b0);
            total++; if (fifo_count !== 4'(i)) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=%0d", fifo_count, i); end
        end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full got=%b exp=1", fifo_full); end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 6'd0, 1'b0);
            total++; if (fifo_dout !== 6'(i)) begin bad++; $display("[TB] FAIL drain_data got=%0d exp=%0d", fifo_dout, i); end
            total++; if (valid_read !== 1'b1) begin bad++; $display("[TB] FAIL drain_valid got=%b exp=1", valid_read); end
        end
        cycle(1'b0, 1'b0, 6'd0, 1'b0);
        total++; if (valid_read !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%b exp=0", valid_read); end
        total++; if (fifo_dout !== 6'd8)  begin bad++; $display("[TB] FAIL idle_dout_hold got=%0d exp=8", fifo_dout); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty got=%b exp=1", fifo_empty); end
        // pointers have wrapped once; a second word must still come back intact
        cycle(1'b1, 1'b0, 6'd33, 1'b0);
        cycle(1'b0, 1'b1, 6'd0, 1'b0);
        total++; if (fifo_dout !== 6'd33) begin bad++; $display("[TB] FAIL wrap_data got=%0d exp=33", fifo_dout); end
    endtask

    task automatic test_overflow();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 6'(40 + i), 1'b0);
        cycle(1'b1, 1'b0, 6'd9, 1'b0);
        total++; if (wr_error !== 1'b1)   begin bad++; $display("[TB] FAIL ovf_wr_error got=%b exp=1", wr_error); end
        total++; if (fifo_error !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky_set got=%b exp=1", fifo_error); end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count got=%0d exp=8", fifo_count); end
        cycle(1'b0, 1'b0, 6'd0, 1'b0);
        total++; if (wr_error !== 1'b0)   begin bad++; $display("[TB] FAIL ovf_pulse_len got=%b exp=0", wr_error); end
        total++; if (fifo_error !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky_hold got=%b exp=1", fifo_error); end
        cycle(1'b1, 1'b0, 6'd9, 1'b1);
        total++; if (fifo_error !== 1'b1) begin bad++; $display("[TB] FAIL set_beats_clr got=%b exp=1", fifo_error); end
        cycle(1'b0, 1'b0, 6'd0, 1'b1);
        total++; if (fifo_error !== 1'b0) begin bad++; $display("[TB] FAIL err_clear got=%b exp=0", fifo_error); end
        cycle(1'b0, 1'b1, 6'd0, 1'b0);
        total++; if (fifo_dout !== 6'd40) begin bad++; $display("[TB] FAIL ovf_no_corrupt got=%0d exp=40", fifo_dout); end
    endtask

    task automatic test_pause();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 6'(i), 1'b0);
            total++; if (pause !== 1'b0) begin bad++; $display("[TB] FAIL pause_fill got=%b exp=0 count=%0d", pause, fifo_count); end
        end
        cycle(1'b0, 1'b0, 6'd0, 1'b0);
        total++; if (pause !== 1'b1) begin bad++; $display("[TB] FAIL pause_set got=%b exp=1", pause); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 6'd0, 1'b0);
            total++; if (pause !== 1'b1) begin bad++; $display("[TB] FAIL pause_hyst got=%b exp=1 count=%0d", pause, fifo_count); end
        end
        total++; if (fifo_count !== 4'd2) begin bad++; $display("[TB] FAIL pause_drain_count got=%0d exp=2", fifo_count); end
        cycle(1'b0, 1'b0, 6'd0, 1'b0);
        total++; if (pause !== 1'b0) begin bad++; $display("[TB] FAIL pause_release got=%b exp=0", pause); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 6'(10 + i), 1'b0);
        cycle(1'b1, 1'b1, 6'd20, 1'b0);
        total++; if (fifo_count !== 4'd8)  begin bad++; $display("[TB] FAIL full_rdwr_count got=%0d exp=8", fifo_count); end
        total++; if (fifo_dout !== 6'd10)  begin bad++; $display("[TB] FAIL full_rdwr_data got=%0d exp=10", fifo_dout); end
        total++; if (wr_error !== 1'b0)    begin bad++; $display("[TB] FAIL full_rdwr_noerr got=%b exp=0", wr_error); end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'd0, 1'b0);
        total++; if (fifo_dout !== 6'd20)  begin bad++; $display("[TB] FAIL full_rdwr_last got=%0d exp=20", fifo_dout); end
        cycle(1'b1, 1'b1, 6'd5, 1'b0);
        total++; if (rd_error !== 1'b1)    begin bad++; $display("[TB] FAIL empty_rdwr_rderr got=%b exp=1", rd_error); end
        total++; if (fifo_count !== 4'd1)  begin bad++; $display("[TB] FAIL empty_rdwr_count got=%0d exp=1", fifo_count); end
        total++; if (valid_read !== 1'b0)  begin bad++; $display("[TB] FAIL empty_rdwr_valid got=%b exp=0", valid_read); end
    endtask

    task automatic test_reset_mid();
        umbral_af = 4'd4;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 6'(i), 1'b0);
        cycle(1'b0, 1'b0, 6'd0, 1'b0);
        total++; if (pause !== 1'b1)       begin bad++; $display("[TB] FAIL mid_pre_pause got=%b exp=1", pause); end
        do_reset(1'b1, 1'b1);
        total++; if (fifo_count !== 4'd0)  begin bad++; $display("[TB] FAIL mid_count got=%0d exp=0", fifo_count); end
        total++; if (fifo_empty !== 1'b1)  begin bad++; $display("[TB] FAIL mid_empty got=%b exp=1", fifo_empty); end
        total++; if (pause !== 1'b0)       begin bad++; $display("[TB] FAIL mid_pause got=%b exp=0", pause); end
        cycle(1'b0, 1'b1, 6'd0, 1'b0);
        total++; if (rd_error !== 1'b1)    begin bad++; $display("[TB] FAIL mid_rd_error got=%b exp=1", rd_error); end
        umbral_af = 4'd6;
    endtask

    task automatic test_random();
        int wr_pct;
        do_reset(1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                umbral_af = 4'($urandom_range(0, 8));
                umbral_ae = 4'($urandom_range(0, 8));
            end
            wr_pct = ((n / 40) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < 50),
                  6'($urandom), ($urandom_range(0, 9) == 0));
            total++; if (fifo_count !== 4'(q.size()))
                begin bad++; $display("[TB] FAIL rnd_count n=%0d got=%0d exp=%0d", n, fifo_count, q.size()); end
            total++; if (valid_read !== exp_valid || (exp_valid && fifo_dout !== exp_dout))
                begin bad++; $display("[TB] FAIL rnd_read n=%0d got=%b/%0d exp=%b/%0d", n, valid_read, fifo_dout, exp_valid, exp_dout); end
            total++; if ({wr_error, rd_error, fifo_error} !== {exp_wr_err, exp_rd_err, exp_err})
                begin bad++; $display("[TB] FAIL rnd_errors n=%0d got=%b exp=%b", n, {wr_error, rd_error, fifo_error}, {exp_wr_err, exp_rd_err, exp_err}); end
            total++; if (pause !== exp_pause)
                begin bad++; $display("[TB] FAIL rnd_pause n=%0d got=%b exp=%b", n, pause, exp_pause); end
            total++; if ({fifo_full, fifo_empty, can_pop, almost_full, almost_empty} !==
                         {q.size() == 8, q.size() == 0, q.size() != 0,
                          q.size() >= int'(umbral_af), q.size() <= int'(umbral_ae)})
                begin bad++; $display("[TB] FAIL rnd_flags n=%0d got=%b size=%0d af=%0d ae=%0d", n,
                      {fifo_full, fifo_empty, can_pop, almost_full, almost_empty}, q.size(), umbral_af, umbral_ae); end
        end
        umbral_af = 4'd6;
        umbral_ae = 4'd2;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        fifo_wr   = 1'b0;
        fifo_rd   = 1'b0;
        fifo_din  = '0;
        error_clr = 1'b0;
        umbral_af = 4'd6;
        umbral_ae = 4'd2;
        exp_pause = 1'b0;
        exp_err   = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
